// File: rtl/npc_ras_unit.sv
// npc_ras_unit
// Fetch-stage next-PC generator. It owns the PC register and a circular
// return-address stack (RAS). Calls push pc+INST_BYTES and returns pop it.
// A return whose RAS prediction differs from the resolved next PC raises a
// one-cycle ret_miss pulse.
//
// Ports
//   clk, rst_n    rising-edge clock; asynchronous active-low reset
//   stall         holds pc and the RAS; suppresses push, pop and miss
//   redirect      external redirect with top priority; target is redirect_pc
//   npc_op[2:1]   00 seq, 01 jal (pc+imm), 10 jalr ((ra+imm)&~1), 11 branch
//   npc_op[0]     branch taken (only used when npc_op[2:1]=11)
//   imm, ra       immediate and register operand
//   is_call       push on call
//   is_ret        pop on return
//   pc            registered PC
//   pc4, npc      pc+INST_BYTES and next PC, both combinational
//   ras_top       top RAS entry, or 0 when the RAS is empty
//   ras_valid     RAS holds at least one entry
//   ret_miss      registered return-mispredict pulse
module npc_ras_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [2:0]      npc_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] ra,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ret_miss
);

  localparam int            PW      = $clog2(RAS_DEPTH);
  localparam int            CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;      // next free slot; top lives at ptr-1
  logic [PW-1:0]   ptr_m1;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_sum;
  logic            has_ent;
  logic            act;
  logic            do_push;
  logic            do_swap;
  logic            do_pop;

  assign pc4      = pc + XLEN'(INST_BYTES);
  assign pc_imm   = pc + imm;
  assign jalr_sum = ra + imm;
  assign ptr_m1   = ptr - PW'(1);
  assign has_ent  = (cnt != '0);
  assign ras_valid = has_ent;
  assign ras_top  = has_ent ? ras[ptr_m1] : '0;

  always_comb begin
    npc = pc4;
    if (redirect) begin
      npc = redirect_pc;
    end else begin
      unique case (npc_op[2:1])
        2'b00:   npc = pc4;
        2'b01:   npc = pc_imm;
        2'b10:   npc = {jalr_sum[XLEN-1:1], 1'b0};
        default: npc = npc_op[0] ? pc_imm : pc4;
      endcase
    end
  end

  // A redirect squashes the instruction, so it never touches the RAS.
  // A call+ret pair on an empty stack degrades to a plain push.
  assign act     = !stall && !redirect;
  assign do_swap = act && is_call && is_ret && has_ent;
  assign do_push = act && is_call && !do_swap;
  assign do_pop  = act && is_ret && !is_call && has_ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ptr      <= '0;
      cnt      <= '0;
      ret_miss <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      if (!stall) pc <= npc;
      ret_miss <= act && is_ret && has_ent && (ras_top != npc);
      if (do_swap) begin
        ras[ptr_m1] <= pc4;
      end else if (do_push) begin
        // Wraps onto the oldest entry once full; cnt just saturates.
        ras[ptr] <= pc4;
        ptr      <= ptr + PW'(1);
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end else if (do_pop) begin
        ptr <= ptr_m1;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/npc_ras_unit.md
Name: npc_ras_unit

Overview:
- Parametrised next-PC generator with its own PC register and a circular return-address stack (RAS).
- Sits at the fetch stage. Computes the next PC from the op code, immediate, register operand and redirect inputs, then registers it.
- Pushes call return addresses onto the RAS, pops them on returns, and flags a return whose RAS prediction disagrees with the resolved target.

Parameters:
- XLEN, 32, datapath / address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INST_BYTES, 4, sequential increment added to pc.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold pc and the RAS; suppresses push, pop and miss.
- redirect  in  1  external redirect (exception/flush); highest priority.
- redirect_pc  in  XLEN  target used when redirect=1.
- npc_op  in  3  next-PC selection, encoded below.
- imm  in  XLEN  sign-extended offset.
- ra  in  XLEN  register operand for jalr.
- is_call  in  1  current instruction is a call (push).
- is_ret  in  1  current instruction is a return (pop).
- pc  out  XLEN  registered current PC.
- pc4  out  XLEN  pc + INST_BYTES, combinational.
- npc  out  XLEN  next PC, combinational.
- ras_top  out  XLEN  top RAS entry; 0 when empty.
- ras_valid  out  1  RAS holds at least one entry.
- ret_miss  out  1  registered one-cycle pulse on a return mispredict.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc=RESET_PC.
  - RAS pointer=0, count=0, entries cleared.
  - ret_miss=0, ras_valid=0, ras_top=0.
  - pc4 and npc follow combinationally from the reset pc.
- npc selection, in priority order:
  - redirect=1: npc=redirect_pc.
  - Otherwise by npc_op[2:1]:
    - 00: pc+INST_BYTES.
    - 01: pc+imm (jal).
    - 10: (ra+imm) with bit 0 forced to 0 (jalr).
    - 11: conditional branch; npc_op[0]=1 selects pc+imm, npc_op[0]=0 selects pc+INST_BYTES.
  - All adds are modulo 2^XLEN; carry is discarded.
- PC register:
  - On a rising edge with stall=0, pc<=npc.
  - With stall=1, pc holds.
  - redirect is ignored while stall=1.
- RAS update on a rising edge, only when stall=0 and redirect=0:
  - Push (is_call=1, is_ret=0):
    - Write pc4 at the pointer, then pointer<=pointer+1 mod RAS_DEPTH.
    - count saturates at RAS_DEPTH.
    - Overflow overwrites the oldest entry silently.
  - Pop (is_ret=1, is_call=0, count>0): pointer<=pointer-1 mod RAS_DEPTH, count<=count-1.
  - Pop with count=0: no state change, and ret_miss is not asserted.
  - Simultaneous call and ret (coroutine swap): overwrite the top entry with pc4; pointer and count unchanged.
    - If count=0, this behaves as a push.
- ras_top is the entry at pointer-1 mod RAS_DEPTH when count>0, else 0.
- ret_miss:
  - Registered. Set to 1 for exactly one cycle after an edge where is_ret=1, stall=0, redirect=0, count>0 and ras_top != npc.
  - Cleared to 0 on every other edge.
  - A stalled return produces no pulse; the pulse is evaluated at the non-stalled edge.
- Latency:
  - npc, pc4, ras_top and ras_valid are combinational, zero cycles.
  - pc, RAS state and ret_miss change one edge after the inputs.
- Reset asserted mid-operation: immediate return to the reset state above, independent of clk; a pending ret_miss is dropped.

Test Plan:
- Reset with RESET_PC=0x100, then release with npc_op=000 for 3 cycles -> pc steps 0x100, 0x104, 0x108, 0x10C; pc4 = pc+4; ras_valid=0.
- pc=0x200, npc_op=110 then 111 with imm=0xFFFFFFF0 -> npc=0x204, then npc=0x1F0. Then npc_op=100, ra=0x3001, imm=0x4 -> npc=0x3004, bit 0 cleared.
- Call at pc=0x400 (push 0x404), then a return with npc_op=100, ra=0x404, imm=0 -> ras_top=0x404 before the edge; pop empties the stack; ret_miss stays 0. Repeat with ra=0x500 -> ret_miss pulses high exactly one cycle.
- Depth overflow (RAS_DEPTH=8): 9 consecutive calls at pc 0x0, 0x4, ... 0x20 -> count saturates at 8. Eight pops return 0x24 down to 0x8, then ras_valid=0. A ninth pop leaves state unchanged with no ret_miss.
- stall=1 with is_call=1 and redirect=1 -> pc, RAS and ret_miss unchanged. Deassert stall with redirect=1, redirect_pc=0x8000 -> pc=0x8000 and no RAS push.
- Assert rst_n low asynchronously between edges after 3 pushes -> pc=RESET_PC, ras_valid=0 and ret_miss=0 immediately, before the next clk edge.
